// File: rtl/risc_pkg.sv
// Shared definitions for the RISC pipeline front end.
// Holds the address and data widths, the default reset PC and the
// pc/instruction pair that travels from fetch to decode.
package risc_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue of fetch_entry_t between the memory response and
// decode. Entry 0 is always the head, so the head fields come straight off
// registers. A flush empties the queue; a head popped in the same cycle is
// still delivered because decode samples it before the clock edge.
module fetch_queue
  import risc_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic [1:0]   o_occ
);

  logic         r_v0;
  logic         r_v1;
  fetch_entry_t r_e0;
  fetch_entry_t r_e1;
  logic         w_pop;

  // A pop only takes effect when there is something at the head
  assign w_pop = i_pop & r_v0;

  // Entry storage and valid flags; the second entry only holds data while the
  // first is occupied, so the occupancy never has holes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_e0 <= '0;
      r_e1 <= '0;
    end else if (i_flush) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else begin
      case ({w_pop, i_push})
        2'b11: begin
          if (r_v1) begin
            r_e0 <= r_e1;
            r_e1 <= i_entry;
          end else begin
            r_e0 <= i_entry;
          end
        end
        2'b10: begin
          if (r_v1) begin
            r_e0 <= r_e1;
          end
          r_v0 <= r_v1;
          r_v1 <= 1'b0;
        end
        2'b01: begin
          if (!r_v0) begin
            r_e0 <= i_entry;
            r_v0 <= 1'b1;
          end else begin
            r_e1 <= i_entry;
            r_v1 <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_head  = r_e0;
  assign o_valid = r_v0;
  assign o_occ   = {r_v1, r_v0 & ~r_v1};

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address, collects
// the word returned one cycle later into a two-entry queue and hands
// pc/instruction pairs to decode over a valid/ready handshake. A taken branch
// redirects the PC and discards everything not already accepted by decode.
// Optional feature: define FETCH_PERF_CNT_EN to add the stall_cycles counter
// (cycles where decode holds back a valid head, saturating at 16'hFFFF).
module instruction_fetch
  import risc_pkg::*;
#(
  parameter int                ADDR_W   = risc_pkg::ADDR_W,
  parameter int                DATA_W   = risc_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = risc_pkg::DEFAULT_RESET_PC
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instr_data,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight_valid;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic              w_arrive;
  logic              w_fire;
  logic              w_issue;
  logic [1:0]        w_occ;
  logic [2:0]        w_occ_next;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  // The response landing this cycle is dropped if a branch redirects
  assign w_arrive = r_inflight_valid & ~br_taken;
  assign w_fire   = out_valid & out_ready;

  // Only issue when the response of this request is sure to find a free slot
  assign w_occ_next = {1'b0, w_occ} + {2'b00, w_arrive} - {2'b00, w_fire};
  assign w_issue    = fetch_en & ~br_taken & (w_occ_next < 3'd2);

  assign w_push_entry = '{pc: r_inflight_pc, instr: instr_data};

  // PC and in-flight tracking; a branch wins over any issue in its cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc             <= RESET_PC;
      r_inflight_valid <= 1'b0;
      r_inflight_pc    <= '0;
    end else if (br_taken) begin
      r_pc             <= br_target;
      r_inflight_valid <= 1'b0;
    end else if (w_issue) begin
      r_inflight_valid <= 1'b1;
      r_inflight_pc    <= r_pc;
      r_pc             <= r_pc + 1'b1;
    end else begin
      r_inflight_valid <= 1'b0;
    end
  end

  fetch_queue u_queue (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_arrive),
    .i_entry (w_push_entry),
    .i_pop   (out_ready),
    .i_flush (br_taken),
    .o_head  (w_head),
    .o_valid (out_valid),
    .o_occ   (w_occ)
  );

  assign instr_addr = r_pc;
  assign out_instr  = w_head.instr;
  assign out_pc     = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_stall_cycles;

  // Count cycles where decode refuses a valid head, holding at the maximum
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= 16'd0;
    end else if (out_valid && !out_ready && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch. Two instances: one with RESET_PC = 0 and
// one with RESET_PC = 16'hFFFF for the wrap-around case. Each has its own
// registered instruction memory model and its own scoreboard of the pc values
// decode is expected to accept, in order.
module tb_instruction_fetch;

  logic        clock = 1'b0;

  logic        reset_n;
  logic        fetchEn;
  logic [15:0] instrAddr;
  logic [15:0] instrData;
  logic        brTaken;
  logic [15:0] brTarget;
  logic        outValid;
  logic        outReady;
  logic [15:0] outInstr;
  logic [15:0] outPc;
  logic [15:0] stallCycles;

  logic        reset2N;
  logic        fetchEn2;
  logic [15:0] instrAddr2;
  logic [15:0] instrData2;
  logic        brTaken2;
  logic [15:0] brTarget2;
  logic        outValid2;
  logic        outReady2;
  logic [15:0] outInstr2;
  logic [15:0] outPc2;
  logic [15:0] stallCycles2;

  logic [15:0] expQ[$];
  logic [15:0] expQ2[$];
  logic [15:0] expPc;
  logic [15:0] expPc2;

  int assertCount = 0;
  int failCount   = 0;

  // Free-running clock shared by both instances and both memories
  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .fetch_en     (fetchEn),
    .instr_addr   (instrAddr),
    .instr_data   (instrData),
    .br_taken     (brTaken),
    .br_target    (brTarget),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_instr    (outInstr),
    .out_pc       (outPc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles (stallCycles)
`endif
  );

  instruction_fetch #(.RESET_PC(16'hFFFF)) dut2 (
    .clock        (clock),
    .reset_n      (reset2N),
    .fetch_en     (fetchEn2),
    .instr_addr   (instrAddr2),
    .instr_data   (instrData2),
    .br_taken     (brTaken2),
    .br_target    (brTarget2),
    .out_valid    (outValid2),
    .out_ready    (outReady2),
    .out_instr    (outInstr2),
    .out_pc       (outPc2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles (stallCycles2)
`endif
  );

  // Memory contents: mem[i] = i below 256, a scrambled value above
  function automatic logic [15:0] memFn(input logic [15:0] a);
    return (a < 16'd256) ? a : (a ^ 16'hA5A5);
  endfunction

  // Registered read memories with one cycle of latency
  always @(posedge clock) begin
    instrData  <= memFn(instrAddr);
    instrData2 <= memFn(instrAddr2);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rdy, input logic br,
                               input logic [15:0] tgt);
    fetchEn  = fe;
    outReady = rdy;
    brTaken  = br;
    brTarget = tgt;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Startup sequence from cycle 0 to cycle lastCycle for the RESET_PC = 0 instance
  task automatic checkStartup(input int lastCycle);
    for (int c = 0; c <= lastCycle; c++) begin
      checkOutput("startAddr", 32'(instrAddr), 32'(c));
      checkOutput("startValid", 32'(outValid), 32'(c >= 2));
      if (c >= 2) checkOutput("startHeadPc", 32'(outPc), 32'(c - 2));
      if (c < lastCycle) tick();
    end
  endtask

  // Scoreboard for the first instance: every accepted output must be next in line
  always @(negedge clock) begin
    if (outValid === 1'b1 && outReady === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("sb1Extra", 32'(expQ.size()), 32'd1);
      end else begin
        expPc = expQ.pop_front();
        checkOutput("sb1Pc", 32'(outPc), 32'(expPc));
        checkOutput("sb1Instr", 32'(outInstr), 32'(memFn(expPc)));
      end
    end
  end

  // Scoreboard for the wrap-around instance
  always @(negedge clock) begin
    if (outValid2 === 1'b1 && outReady2 === 1'b1) begin
      if (expQ2.size() == 0) begin
        checkOutput("sb2Extra", 32'(expQ2.size()), 32'd1);
      end else begin
        expPc2 = expQ2.pop_front();
        checkOutput("sb2Pc", 32'(outPc2), 32'(expPc2));
        checkOutput("sb2Instr", 32'(outInstr2), 32'(memFn(expPc2)));
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    reset2N   = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    fetchEn2  = 1'b1;
    outReady2 = 1'b1;
    brTaken2  = 1'b0;
    brTarget2 = 16'h0000;
    repeat (3) tick();

    // Reset state
    checkOutput("rstValid", 32'(outValid), 32'd0);
    checkOutput("rstAddr", 32'(instrAddr), 32'd0);
    checkOutput("rstOutPc", 32'(outPc), 32'd0);
    checkOutput("rstOutInstr", 32'(outInstr), 32'd0);
    checkOutput("rst2Addr", 32'(instrAddr2), 32'hFFFF);
    checkOutput("rst2Valid", 32'(outValid2), 32'd0);

    // Startup and streaming; head 9 is the last one accepted before the branch
    for (int i = 0; i < 10; i++) expQ.push_back(16'(i));
    reset_n = 1'b1;
    checkStartup(7);

    // Backpressure for cycles 7..10 while the head is 5
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int c = 8; c <= 10; c++) begin
      tick();
      checkOutput("bpAddr", 32'(instrAddr), 32'd7);
      checkOutput("bpHeadPc", 32'(outPc), 32'd5);
      checkOutput("bpValid", 32'(outValid), 32'd1);
    end
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("bpStall", 32'(stallCycles), 32'd4);
`endif
    for (int c = 11; c <= 15; c++) begin
      if (c > 11) tick();
      checkOutput("drainValid", 32'(outValid), 32'd1);
      checkOutput("drainHeadPc", 32'(outPc), 32'(c - 6));
    end

    // Branch to 170 in cycle 15 while head 9 is accepted
    applyStimulus(1'b1, 1'b1, 1'b1, 16'd170);
    expQ.push_back(16'd170);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("brAddr", 32'(instrAddr), 32'd170);
    checkOutput("brValidK1", 32'(outValid), 32'd0);
    tick();
    checkOutput("brValidK2", 32'(outValid), 32'd0);
    tick();
    checkOutput("brValidK3", 32'(outValid), 32'd1);
    checkOutput("brHeadPc", 32'(outPc), 32'd170);
    checkOutput("brHeadInstr", 32'(outInstr), 32'd170);
    tick();
    checkOutput("brNextInstr", 32'(outInstr), 32'd171);

    // Fill the queue with decode stalled, then branch to 231
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("fullAddr", 32'(instrAddr), 32'd173);
    tick();
    checkOutput("fullAddrHold", 32'(instrAddr), 32'd173);
    checkOutput("fullHeadPc", 32'(outPc), 32'd171);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd231);
    expQ.push_back(16'd231);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("flushAddr", 32'(instrAddr), 32'd231);
    checkOutput("flushValid", 32'(outValid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("flushStall", 32'(stallCycles), 32'd7);
`endif
    tick();
    checkOutput("flushValidK2", 32'(outValid), 32'd0);
    tick();
    checkOutput("flushHeadPc", 32'(outPc), 32'd231);
    checkOutput("flushHeadInstr", 32'(outInstr), 32'd231);
    tick();
    checkOutput("flushNextPc", 32'(outPc), 32'd232);

    // Asynchronous reset between clock edges, then the startup sequence again
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncValid", 32'(outValid), 32'd0);
    checkOutput("asyncAddr", 32'(instrAddr), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("asyncStall", 32'(stallCycles), 32'd0);
`endif
    tick();
    tick();
    for (int i = 0; i < 5; i++) expQ.push_back(16'(i));
    reset_n = 1'b1;
    checkStartup(6);
    #5;
    outReady = 1'b0;
    checkOutput("sb1Drained", 32'(expQ.size()), 32'd0);

    // Wrap-around from 16'hFFFF and a three-cycle fetch_en gap
    expQ2.push_back(16'hFFFF);
    for (int i = 0; i < 5; i++) expQ2.push_back(16'(i));
    reset2N = 1'b1;
    checkOutput("wrapAddrC0", 32'(instrAddr2), 32'hFFFF);
    tick();
    checkOutput("wrapAddrC1", 32'(instrAddr2), 32'h0000);
    tick();
    checkOutput("wrapHeadC2", 32'(outPc2), 32'hFFFF);
    tick();
    checkOutput("wrapHeadC3", 32'(outPc2), 32'h0000);
    tick();
    checkOutput("wrapHeadC4", 32'(outPc2), 32'h0001);
    checkOutput("wrapAddrC4", 32'(instrAddr2), 32'h0003);
    fetchEn2 = 1'b0;
    tick();
    checkOutput("gapHeadC5", 32'(outPc2), 32'h0002);
    checkOutput("gapAddrC5", 32'(instrAddr2), 32'h0003);
    tick();
    checkOutput("gapValidC6", 32'(outValid2), 32'd0);
    checkOutput("gapAddrC6", 32'(instrAddr2), 32'h0003);
    tick();
    checkOutput("gapAddrC7", 32'(instrAddr2), 32'h0003);
    fetchEn2 = 1'b1;
    tick();
    checkOutput("gapAddrC8", 32'(instrAddr2), 32'h0004);
    checkOutput("gapValidC8", 32'(outValid2), 32'd0);
    tick();
    checkOutput("gapHeadC9", 32'(outPc2), 32'h0003);
    tick();
    checkOutput("gapHeadC10", 32'(outPc2), 32'h0004);
    #5;
    outReady2 = 1'b0;
    checkOutput("sb2Drained", 32'(expQ2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
